// File: rtl/huffman_pkg.sv
// Shared defaults, length-width helper and FSM encoding for the Huffman code
// table with serial emitter.
package huffman_pkg;

  localparam int SYM_W_DEF   = 7;
  localparam int MAX_LEN_DEF = 128;
  localparam int OUT_W_DEF   = 8;

  // Smallest width that can still represent max_len itself.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/huffman_code_table_ser_code_serializer.sv
// MSB-first serializer: holds a left-aligned code and emits it in OUT_W-bit
// beats, tracking how many code bits are still pending.
module code_serializer
  import huffman_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = len_w(MAX_LEN_DEF),
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic               clock,
  input  logic               ctrl_reset,
  input  logic               load,
  input  logic [MAX_LEN-1:0] ld_code,
  input  logic [LEN_W-1:0]   ld_len,
  input  logic               advance,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_bits,
  output logic [LEN_W-1:0]   out_nbits,
  output logic               out_last,
  output logic               done
);

  localparam logic [LEN_W:0]   MAX_LEN_L = (LEN_W + 1)'(MAX_LEN);
  localparam logic [LEN_W-1:0] OUT_W_L   = LEN_W'(OUT_W);

  logic [MAX_LEN-1:0] shift_q, shift_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [LEN_W:0]     shamt_s;

  // Bits above the code length fall off the top, so emptied positions are zero.
  assign shamt_s   = MAX_LEN_L - {1'b0, ld_len};
  assign out_valid = (rem_q != '0);
  assign out_last  = out_valid && (rem_q <= OUT_W_L);
  assign out_nbits = (rem_q >= OUT_W_L) ? OUT_W_L : rem_q;
  assign out_bits  = shift_q[MAX_LEN-1 -: OUT_W];
  assign done      = out_last && advance;

  // Next-state for the shift register and pending-bit counter.
  always_comb begin
    shift_d = shift_q;
    rem_d   = rem_q;
    if (load) begin
      shift_d = ld_code << shamt_s;
      rem_d   = ld_len;
    end else if (out_valid && advance) begin
      shift_d = shift_q << OUT_W;
      rem_d   = rem_q - out_nbits;
    end else begin
      shift_d = shift_q;
      rem_d   = rem_q;
    end
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      shift_q <= '0;
      rem_q   <= '0;
    end else begin
      shift_q <= shift_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: rtl/huffman_code_table_ser.sv
// Huffman symbol-to-code table with per-entry valid bits and a lookup FSM that
// streams each code MSB-first through the serializer.
module huffman_code_table_ser
  import huffman_pkg::*;
#(
  parameter int SYM_W   = SYM_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = len_w(MAX_LEN_DEF),
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic               clock,
  input  logic               ctrl_reset,
  input  logic               ctrl_write,
  input  logic [SYM_W-1:0]   wr_sym,
  input  logic [MAX_LEN-1:0] wr_code,
  input  logic [LEN_W-1:0]   wr_len,
  input  logic               sym_valid,
  output logic               sym_ready,
  input  logic [SYM_W-1:0]   sym,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_bits,
  output logic [LEN_W-1:0]   out_nbits,
  output logic               out_last,
  output logic               err_unmapped,
  output logic               err_wrlen
);

  localparam int               DEPTH     = 2 ** SYM_W;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] code_mem [DEPTH];
  logic [LEN_W-1:0]   len_mem  [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  state_e             state_q, state_d;
  logic [SYM_W-1:0]   sym_q, sym_d;
  logic               err_unmapped_q, err_unmapped_d;
  logic               err_wrlen_q, err_wrlen_d;
  logic               wr_ok_s, load_s, done_s;

  assign sym_ready    = (state_q == ST_IDLE);
  assign err_unmapped = err_unmapped_q;
  assign err_wrlen    = err_wrlen_q;

  // Table write decode and entry-valid update.
  always_comb begin
    wr_ok_s     = ctrl_write && (wr_len != '0) && (wr_len <= MAX_LEN_L);
    err_wrlen_d = ctrl_write && (wr_len > MAX_LEN_L);
    valid_d     = valid_q;
    if (ctrl_write && (wr_len == '0)) begin
      valid_d[wr_sym] = 1'b0;
    end else if (wr_ok_s) begin
      valid_d[wr_sym] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // Storage is not reset; every read is qualified by valid_q.
  always_ff @(posedge clock) begin
    if (wr_ok_s) begin
      code_mem[wr_sym] <= wr_code;
      len_mem[wr_sym]  <= wr_len;
    end
  end

  // Lookup FSM: accept, read the entry in LOAD, then hand off to the serializer.
  always_comb begin
    state_d        = state_q;
    sym_d          = sym_q;
    err_unmapped_d = 1'b0;
    load_s         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sym_valid) begin
          sym_d   = sym;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (valid_q[sym_q]) begin
          load_s  = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          err_unmapped_d = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state_q        <= ST_IDLE;
      sym_q          <= '0;
      valid_q        <= '0;
      err_unmapped_q <= 1'b0;
      err_wrlen_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      sym_q          <= sym_d;
      valid_q        <= valid_d;
      err_unmapped_q <= err_unmapped_d;
      err_wrlen_q    <= err_wrlen_d;
    end
  end

  code_serializer #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .OUT_W   (OUT_W)
  ) u_ser (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .load       (load_s),
    .ld_code    (code_mem[sym_q]),
    .ld_len     (len_mem[sym_q]),
    .advance    (out_ready),
    .out_valid  (out_valid),
    .out_bits   (out_bits),
    .out_nbits  (out_nbits),
    .out_last   (out_last),
    .done       (done_s)
  );

endmodule

// File: tb/tb_huffman_code_table_ser.sv
// Directed plus randomized bench for huffman_code_table_ser against a table
// model that slices each code into beats arithmetically.
module tb_huffman_code_table_ser;

  localparam int SYM_W   = 7;
  localparam int MAX_LEN = 128;
  localparam int LEN_W   = 8;
  localparam int OUT_W   = 8;

  logic               clock = 1'b0;
  logic               ctrl_reset = 1'b1;
  logic               ctrl_write = 1'b0;
  logic [SYM_W-1:0]   wr_sym = '0;
  logic [MAX_LEN-1:0] wr_code = '0;
  logic [LEN_W-1:0]   wr_len = '0;
  logic               sym_valid = 1'b0;
  logic               sym_ready;
  logic [SYM_W-1:0]   sym = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [OUT_W-1:0]   out_bits;
  logic [LEN_W-1:0]   out_nbits;
  logic               out_last;
  logic               err_unmapped;
  logic               err_wrlen;

  int checks = 0;
  int failures = 0;

  logic [MAX_LEN-1:0] m_code  [128];
  int                 m_len   [128];
  bit                 m_valid [128];

  always #5 clock = ~clock;

  huffman_code_table_ser dut (
    .clock        (clock),
    .ctrl_reset   (ctrl_reset),
    .ctrl_write   (ctrl_write),
    .wr_sym       (wr_sym),
    .wr_code      (wr_code),
    .wr_len       (wr_len),
    .sym_valid    (sym_valid),
    .sym_ready    (sym_ready),
    .sym          (sym),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bits     (out_bits),
    .out_nbits    (out_nbits),
    .out_last     (out_last),
    .err_unmapped (err_unmapped),
    .err_wrlen    (err_wrlen)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat k of a len-bit code: the next bits from the top, MSB-aligned in 8 bits.
  function automatic logic [7:0] exp_beat(input logic [127:0] code, input int len, input int k);
    int rem, n;
    logic [127:0] t;
    logic [7:0] v;
    rem = len - 8 * k;
    n = (rem > 8) ? 8 : rem;
    t = code >> (rem - n);
    v = t[7:0];
    if (n < 8) v = v & 8'((1 << n) - 1);
    return v << (8 - n);
  endfunction

  function automatic int exp_nbits(input int len, input int k);
    int rem;
    rem = len - 8 * k;
    return (rem > 8) ? 8 : rem;
  endfunction

  task automatic set_write(input logic [6:0] s, input logic [127:0] code, input int len);
    ctrl_write = 1'b1;
    wr_sym     = s;
    wr_code    = code;
    wr_len     = 8'(len);
    if (len == 0) begin
      m_valid[s] = 1'b0;
    end else if (len <= MAX_LEN) begin
      m_valid[s] = 1'b1;
      m_code[s]  = code;
      m_len[s]   = len;
    end
  endtask

  task automatic do_write(input logic [6:0] s, input logic [127:0] code, input int len);
    @(negedge clock);
    set_write(s, code, len);
    @(negedge clock);
    ctrl_write = 1'b0;
    chk("err_wrlen", err_wrlen, (len > MAX_LEN) ? 1 : 0);
    @(negedge clock);
    chk("err_wrlen_clr", err_wrlen, 0);
  endtask

  // mode 0: plain lookup; 1: write same symbol in acceptance cycle; 2: write in LOAD cycle.
  task automatic send_sym(input logic [6:0] s, input int mode, input logic [127:0] wcode,
                          input int wlen, input int stall_beat, input int stall_cyc);
    logic [127:0] e_code;
    int e_len, nb;
    bit e_valid;
    @(negedge clock);
    chk("idle_ready", sym_ready, 1);
    chk("idle_bits", out_bits, 0);
    sym_valid = 1'b1;
    sym       = s;
    if (mode == 1) set_write(s, wcode, wlen);
    e_code  = m_code[s];
    e_len   = m_len[s];
    e_valid = m_valid[s];
    @(negedge clock);
    sym_valid  = 1'b0;
    ctrl_write = 1'b0;
    chk("load_ready", sym_ready, 0);
    chk("load_ovalid", out_valid, 0);
    if (mode == 2) set_write(s, wcode, wlen);
    @(negedge clock);
    ctrl_write = 1'b0;
    if (!e_valid) begin
      chk("unmapped_pulse", err_unmapped, 1);
      chk("unmapped_ovalid", out_valid, 0);
      chk("unmapped_ready", sym_ready, 1);
      @(negedge clock);
      chk("unmapped_clr", err_unmapped, 0);
      chk("unmapped_ovalid2", out_valid, 0);
    end else begin
      nb = (e_len + 7) / 8;
      for (int k = 0; k < nb; k++) begin
        for (int c = 0; c < ((k == stall_beat) ? stall_cyc : 0); c++) begin
          out_ready = 1'b0;
          chk("stall_valid", out_valid, 1);
          chk("stall_bits", out_bits, exp_beat(e_code, e_len, k));
          chk("stall_nbits", out_nbits, exp_nbits(e_len, k));
          chk("stall_last", out_last, (k == nb - 1) ? 1 : 0);
          @(negedge clock);
        end
        out_ready = 1'b1;
        chk("beat_valid", out_valid, 1);
        chk("beat_bits", out_bits, exp_beat(e_code, e_len, k));
        chk("beat_nbits", out_nbits, exp_nbits(e_len, k));
        chk("beat_last", out_last, (k == nb - 1) ? 1 : 0);
        chk("beat_noerr", err_unmapped, 0);
        @(negedge clock);
      end
      chk("end_ovalid", out_valid, 0);
      chk("end_ready", sym_ready, 1);
      chk("end_bits", out_bits, 0);
    end
  endtask

  initial begin
    logic [127:0] ones;
    logic [127:0] rcode;
    logic [6:0] rs;
    int rlen;
    ones = '1;
    for (int i = 0; i < 128; i++) begin
      m_valid[i] = 1'b0;
      m_code[i]  = '0;
      m_len[i]   = 0;
    end

    // Reset state.
    repeat (2) @(negedge clock);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_bits", out_bits, 0);
    chk("rst_nbits", out_nbits, 0);
    chk("rst_last", out_last, 0);
    chk("rst_unmapped", err_unmapped, 0);
    chk("rst_wrlen", err_wrlen, 0);
    ctrl_reset = 1'b0;
    @(negedge clock);
    chk("rst_ready", sym_ready, 1);

    // Short code, long code with stall, unmapped symbol.
    do_write(7'h41, 128'b101, 3);
    send_sym(7'h41, 0, '0, 0, -1, 0);
    do_write(7'h05, 128'hABCDE, 20);
    send_sym(7'h05, 0, '0, 0, 1, 3);
    send_sym(7'h7F, 0, '0, 0, -1, 0);

    // Rejected length, then delete.
    do_write(7'h10, 128'h1234, 200);
    send_sym(7'h10, 0, '0, 0, -1, 0);
    do_write(7'h41, '0, 0);
    send_sym(7'h41, 0, '0, 0, -1, 0);

    // Maximum-length code.
    do_write(7'h00, ones, 128);
    send_sym(7'h00, 0, '0, 0, -1, 0);

    // Write collisions in the acceptance cycle and in LOAD.
    do_write(7'h22, 128'h5A, 8);
    send_sym(7'h22, 1, 128'h3, 2, -1, 0);
    send_sym(7'h22, 2, 128'hF, 4, 0, 1);
    send_sym(7'h22, 0, '0, 0, -1, 0);

    // Reset during SHIFT drops the emission and clears the table.
    @(negedge clock);
    sym_valid = 1'b1;
    sym       = 7'h05;
    @(negedge clock);
    sym_valid = 1'b0;
    @(negedge clock);
    chk("pre_rst_valid", out_valid, 1);
    ctrl_reset = 1'b1;
    @(negedge clock);
    ctrl_reset = 1'b0;
    chk("mid_rst_ovalid", out_valid, 0);
    chk("mid_rst_ready", sym_ready, 1);
    chk("mid_rst_bits", out_bits, 0);
    for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
    send_sym(7'h05, 0, '0, 0, -1, 0);

    // Randomized writes and lookups over a small symbol set.
    for (int it = 0; it < 40; it++) begin
      rs = 7'($urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0) begin
        rcode = {$urandom, $urandom, $urandom, $urandom};
        case ($urandom_range(0, 5))
          0:       rlen = 0;
          1:       rlen = $urandom_range(129, 255);
          2:       rlen = $urandom_range(100, 128);
          default: rlen = $urandom_range(1, 40);
        endcase
        do_write(rs, rcode, rlen);
      end
      send_sym(rs, 0, '0, 0, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/huffman_code_table_ser.md
Name: huffman_code_table_ser

Overview:
Parametrised Huffman translation table with a built-in bit-serial code emitter. It is the successor to the flat ASCII-to-code lookup table and sits between the symbol source and the bitstream packer. The block stores one right-justified code and its length per symbol. Each accepted symbol is looked up and its code is streamed MSB-first in OUT_W-bit beats over a valid/ready handshake.

Parameters:
SYM_W, 7, symbol width; table depth is 2**SYM_W.
MAX_LEN, 128, maximum code length in bits; also the width of wr_code.
LEN_W, 8, length field width; must satisfy 2**LEN_W > MAX_LEN, so that MAX_LEN itself is representable.
OUT_W, 8, bits per output beat.

Ports:
clock  in  1  single clock; all state updates on the rising edge.
ctrl_reset  in  1  synchronous, active-high reset.
ctrl_write  in  1  table write enable.
wr_sym  in  SYM_W  symbol to write.
wr_code  in  MAX_LEN  code, right-justified; bits above wr_len are ignored.
wr_len  in  LEN_W  code length; 0 deletes the entry.
sym_valid  in  1  lookup request valid.
sym_ready  out  1  block can accept a symbol.
sym  in  SYM_W  symbol to encode.
out_valid  out  1  output beat valid.
out_ready  in  1  downstream accepts the beat.
out_bits  out  OUT_W  code bits; the first bit is in the MSB, and unused low bits are 0.
out_nbits  out  LEN_W  number of valid bits in out_bits, from 1 to OUT_W.
out_last  out  1  marks the final beat of the current symbol.
err_unmapped  out  1  one-cycle pulse: the looked-up symbol has no valid entry.
err_wrlen  out  1  one-cycle pulse: a write was rejected because wr_len > MAX_LEN.

Behaviour:
- Reset (synchronous, active-high, dominates every other input):
  - FSM goes to IDLE and all entry-valid bits clear.
  - out_valid, out_bits, out_nbits, out_last, err_unmapped and err_wrlen are all 0; sym_ready is 1 in the cycle after reset.
  - Any in-flight symbol is dropped.
  - Code storage contents need not be reset; reads are gated by the valid bit.
- Writes are accepted in any FSM state and commit at the clock edge:
  - wr_len from 1 to MAX_LEN: store the code and length, set valid.
  - wr_len == 0: clear valid.
  - wr_len > MAX_LEN: no change; err_wrlen pulses in the next cycle.
- FSM states:
  - IDLE: sym_ready = 1. On sym_valid & sym_ready, capture sym and go to LOAD.
  - LOAD: sym_ready = 0. Read the entry combinationally from storage and register it at the end of the cycle.
    - Entry invalid: err_unmapped pulses in the next cycle; return to IDLE with no output beat.
    - Entry valid: load the shift register with the code left-aligned to MSB; set remaining = len; go to SHIFT.
  - SHIFT: out_valid = 1; out_nbits = min(OUT_W, remaining); out_last = (remaining <= OUT_W).
    - On out_ready: shift left by OUT_W and set remaining -= out_nbits.
    - If out_last, go to IDLE.
    - While out_valid & !out_ready, all outputs hold stable.
- Latency: symbol accepted at edge N; first beat valid in cycle N+2.
- Throughput: a code of length L occupies 2 + ceil(L/OUT_W) cycles when out_ready = 1. There is no overlap between symbols.
- Write collisions:
  - A write to the looked-up symbol in the acceptance cycle is visible in LOAD.
  - A write in the LOAD cycle is not visible (old value emitted).
  - Writes during SHIFT never affect the current emission.
- Width rules: remaining is LEN_W bits and never underflows. The shift register is MAX_LEN bits and zero-fills from the LSB.

Decomposition:
- Package huffman_pkg holds:
  - SYM_W and MAX_LEN defaults.
  - A clog2-based LEN_W helper.
  - The FSM state enum {IDLE, LOAD, SHIFT}.
- One sub-module, code_serializer, holds the shift register, the remaining counter, and the out_bits/out_nbits/out_last generation. It has load, advance and done signals.
- Table storage and the FSM stay in the top module.

Test Plan:
- Write 0x41 code=0b101 len=3; send sym 0x41 with out_ready=1 -> cycle+2: out_bits=8'hA0, out_nbits=3, out_last=1; sym_ready=1 two cycles later.
- Write 0x05 code=20'hABCDE len=20; send 0x05, drop out_ready for 3 cycles on beat 2 -> beats 0xAB/8, 0xCD/8, 0xE0/4+last; beat 2 holds stable while stalled.
- Send unwritten 0x7F -> err_unmapped pulse once in cycle+2; out_valid stays 0; sym_ready returns to 1.
- Write 0x10 len=200 -> err_wrlen pulse, entry unchanged. Then write 0x41 len=0 and send 0x41 -> err_unmapped.
- Write 0x00 with len=128, all-ones code; send 0x00 -> 16 beats of 0xFF/8, out_last only on beat 16.
- Assert ctrl_reset during SHIFT of a 20-bit code -> next cycle out_valid=0, sym_ready=1; a lookup of 0x05 then reports err_unmapped.
